// File: rtl/frame_config_loader.sv
// Configuration-port driver for one fabric region: decodes a 32-bit command
// stream into per-row FrameData registers and one-hot per-column FrameStrobe
// pulses for the tile configuration memories.
module frame_config_loader #(
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned NumRows         = 4,
    parameter int unsigned NumCols         = 4,
    parameter int unsigned StrobeCycles    = 2,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
    input  logic                                 CLK,
    input  logic                                 resetn,
    input  logic [31:0]                          s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
    output logic [NumCols*MaxFramesPerCol-1:0]   FrameStrobe,
    output logic                                 busy,
    output logic                                 cfg_done,
    output logic                                 err
);

    localparam int unsigned DATA_W = NumRows * FrameBitsPerRow;
    localparam int unsigned STB_W  = NumCols * MaxFramesPerCol;
    localparam int unsigned CNT_W  = $clog2(StrobeCycles + 1);

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_WRITE  = 4'h1;
    localparam logic [3:0] OP_STROBE = 4'h2;
    localparam logic [3:0] OP_DESYNC = 4'h3;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_CMD,
        ST_DATA,
        ST_STROBE,
        ST_HOLD
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         row_q;

    logic               accept;
    logic [3:0]         op;
    logic [7:0]         cmd_row;
    logic [7:0]         cmd_col;
    logic [7:0]         cmd_frame;
    logic               strobe_ok;
    logic               row_ok;
    logic [31:0]        strobe_idx;

    // Command field decode and range checks
    always_comb begin
        accept     = s_valid && s_ready;
        op         = s_data[31:28];
        cmd_row    = s_data[7:0];
        cmd_col    = s_data[15:8];
        cmd_frame  = s_data[23:16];
        strobe_ok  = (32'(cmd_col) < NumCols) && (32'(cmd_frame) < MaxFramesPerCol);
        row_ok     = 32'(row_q) < NumRows;
        strobe_idx = 32'(cmd_col) * MaxFramesPerCol + 32'(cmd_frame);
    end

    // Command FSM with registered handshake, status and frame outputs
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_SYNC;
            s_ready     <= 1'b1;
            busy        <= 1'b0;
            cfg_done    <= 1'b0;
            err         <= 1'b0;
            FrameData   <= DATA_W'(0);
            FrameStrobe <= STB_W'(0);
            cnt         <= CNT_W'(0);
            row_q       <= 8'd0;
        end else begin
            cfg_done <= 1'b0;
            unique case (state)
                ST_SYNC: begin
                    if (accept && (s_data == SyncWord)) begin
                        state <= ST_CMD;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                    end
                end
                ST_CMD: begin
                    // A repeated sync word in CMD is tolerated as a NOP
                    if (accept && (s_data != SyncWord)) begin
                        unique case (op)
                            OP_NOP: begin
                                state <= ST_CMD;
                            end
                            OP_WRITE: begin
                                row_q <= cmd_row;
                                state <= ST_DATA;
                            end
                            OP_STROBE: begin
                                if (strobe_ok) begin
                                    FrameStrobe <= STB_W'(1) << strobe_idx;
                                    cnt         <= CNT_W'(StrobeCycles);
                                    s_ready     <= 1'b0;
                                    state       <= ST_STROBE;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            OP_DESYNC: begin
                                state    <= ST_SYNC;
                                busy     <= 1'b0;
                                cfg_done <= 1'b1;
                            end
                            default: begin
                                err <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        if (row_ok) begin
                            for (int r = 0; r < int'(NumRows); r++) begin
                                if (32'(row_q) == 32'(r)) begin
                                    FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <=
                                        FrameBitsPerRow'(s_data);
                                end
                            end
                        end else begin
                            err <= 1'b1;
                        end
                        state <= ST_CMD;
                    end
                end
                ST_STROBE: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        FrameStrobe <= STB_W'(0);
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    s_ready <= 1'b1;
                    state   <= ST_CMD;
                end
                default: begin
                    state   <= ST_SYNC;
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_config_loader.sv
// Directed bench for frame_config_loader: expected values are queued when a
// step is driven and popped when the corresponding DUT output is sampled.
module tb_frame_config_loader;

    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

    logic         CLK = 1'b0;
    logic         resetn;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] FrameData;
    logic [79:0]  FrameStrobe;
    logic         busy;
    logic         cfg_done;
    logic         err;

    int           n_checks = 0;
    int           n_pass   = 0;

    string        tag_q[$];
    logic [127:0] exp_q[$];
    logic [127:0] exp_fd;
    logic [127:0] one;

    frame_config_loader dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .cfg_done    (cfg_done),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input string tag, input logic [127:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic chk(input logic [127:0] obs);
        string        tag;
        logic [127:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %0h expected queued entry", obs);
        end else begin
            tag = tag_q.pop_front();
            e   = exp_q.pop_front();
            assert (obs === e) n_pass++;
            else $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
        end
    endtask

    // Present a word at a falling edge and hold it until one rising edge with s_ready
    task automatic send(input logic [31:0] w);
        int n;
        n       = 0;
        s_data  = w;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 64) begin
            @(negedge CLK);
            n++;
        end
        n_checks++;
        assert (s_ready === 1'b1) n_pass++;
        else $error("FAIL send_timeout: observed s_ready=%b expected 1 within 64 cycles", s_ready);
        @(negedge CLK);
        s_valid = 1'b0;
    endtask

    initial begin
        one     = 128'd1;
        exp_fd  = 128'd0;
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'd0;

        // Reset state
        repeat (2) @(negedge CLK);
        push_exp("rst_s_ready", 128'd1);     chk(128'(s_ready));
        push_exp("rst_busy", 128'd0);        chk(128'(busy));
        push_exp("rst_framedata", 128'd0);   chk(FrameData);
        push_exp("rst_framestrobe", 128'd0); chk(128'(FrameStrobe));
        push_exp("rst_err", 128'd0);         chk(128'(err));
        push_exp("rst_cfg_done", 128'd0);    chk(128'(cfg_done));
        resetn = 1'b1;
        @(negedge CLK);

        // Non-sync word discarded, then sync
        push_exp("discard_busy", 128'd0);
        send(32'h1234_5678);
        chk(128'(busy));
        push_exp("sync_busy", 128'd1);
        send(SYNC_WORD);
        chk(128'(busy));
        push_exp("sync_framedata", 128'd0);  chk(FrameData);
        push_exp("sync_err", 128'd0);        chk(128'(err));

        // Row writes
        exp_fd[64 +: 32] = 32'hDEAD_BEEF;
        push_exp("fd_row2", exp_fd);
        send(32'h1000_0002);
        send(32'hDEAD_BEEF);
        chk(FrameData);
        push_exp("row2_no_strobe", 128'd0);  chk(128'(FrameStrobe));
        exp_fd[0 +: 32] = 32'h1111_2222;
        push_exp("fd_row0", exp_fd);
        send(32'h1000_0000);
        send(32'h1111_2222);
        chk(FrameData);

        // Strobe col 1 frame 5 with s_valid held high throughout
        s_data  = 32'h2005_0103;
        s_valid = 1'b1;
        @(negedge CLK);
        s_data = 32'h1000_0001;
        push_exp("stb_cyc1", one << 25);     chk(128'(FrameStrobe));
        push_exp("rdy_cyc1", 128'd0);        chk(128'(s_ready));
        push_exp("fd_cyc1", exp_fd);         chk(FrameData);
        @(negedge CLK);
        push_exp("stb_cyc2", one << 25);     chk(128'(FrameStrobe));
        push_exp("rdy_cyc2", 128'd0);        chk(128'(s_ready));
        @(negedge CLK);
        push_exp("stb_cyc3", 128'd0);        chk(128'(FrameStrobe));
        push_exp("rdy_cyc3", 128'd0);        chk(128'(s_ready));
        push_exp("fd_hold", exp_fd);         chk(FrameData);
        @(negedge CLK);
        push_exp("rdy_cyc4", 128'd1);        chk(128'(s_ready));
        @(negedge CLK);
        s_data = 32'hCAFE_F00D;
        @(negedge CLK);
        s_valid = 1'b0;
        exp_fd[32 +: 32] = 32'hCAFE_F00D;
        push_exp("fd_row1_after_stall", exp_fd); chk(FrameData);

        // Out-of-range strobe and row
        push_exp("err_before", 128'd0);      chk(128'(err));
        send(32'h2014_0000);
        push_exp("err_frame_oor", 128'd1);   chk(128'(err));
        push_exp("stb_frame_oor", 128'd0);   chk(128'(FrameStrobe));
        push_exp("rdy_no_stall", 128'd1);    chk(128'(s_ready));
        send(32'h1000_0009);
        send(32'h5555_AAAA);
        push_exp("fd_bad_row", exp_fd);      chk(FrameData);
        push_exp("err_sticky", 128'd1);      chk(128'(err));
        send(32'h2000_0400);
        push_exp("stb_col_oor", 128'd0);     chk(128'(FrameStrobe));

        // Desync
        send(32'h3000_0000);
        push_exp("done_pulse", 128'd1);      chk(128'(cfg_done));
        push_exp("desync_busy", 128'd0);     chk(128'(busy));
        @(negedge CLK);
        push_exp("done_clear", 128'd0);      chk(128'(cfg_done));
        push_exp("err_after_desync", 128'd1); chk(128'(err));
        send(32'h1000_0000);
        send(32'h0000_1234);
        push_exp("sync_discard_busy", 128'd0); chk(128'(busy));
        push_exp("fd_after_desync", exp_fd);   chk(FrameData);

        // Resync clears err; sync word inside CMD is a NOP
        send(SYNC_WORD);
        push_exp("resync_err", 128'd0);      chk(128'(err));
        push_exp("resync_busy", 128'd1);     chk(128'(busy));
        send(SYNC_WORD);
        send(32'h1000_0003);
        send(32'h0BAD_F00D);
        exp_fd[96 +: 32] = 32'h0BAD_F00D;
        push_exp("fd_row3", exp_fd);         chk(FrameData);
        push_exp("cmd_sync_no_err", 128'd0); chk(128'(err));

        // Asynchronous reset in the middle of a strobe (top strobe bit)
        send(32'h2013_0300);
        push_exp("stb_top_bit", one << 79);  chk(128'(FrameStrobe));
        resetn = 1'b0;
        #1;
        exp_fd = 128'd0;
        push_exp("async_rst_strobe", 128'd0); chk(128'(FrameStrobe));
        push_exp("async_rst_fd", exp_fd);     chk(FrameData);
        @(negedge CLK);
        resetn = 1'b1;
        @(negedge CLK);
        push_exp("post_rst_ready", 128'd1);  chk(128'(s_ready));
        push_exp("post_rst_busy", 128'd0);   chk(128'(busy));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
